// File: rtl/mdu_hilo.sv
// mdu_hilo: E-stage multiply/divide unit owning the HI/LO registers.
// A MULT/MULTU/DIV/DIVU result is computed in the start cycle, parked in
// pending registers, and committed to HI/LO when the busy countdown expires.
// MTHI/MTLO write HI/LO directly while idle; MFHI/MFLO read them combinationally.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  hilo_op,
    input  logic [1:0]  write_hl,
    input  logic [1:0]  read_hl,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hilo_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Signed 32x32 product: sign-extend both operands, keep the low 64 bits.
    function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    // Unsigned 32x32 product.
    function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {32'd0, a};
        eb = {32'd0, b};
        return ea * eb;
    endfunction

    // Signed divide on magnitudes: quotient truncates toward zero, remainder
    // takes the dividend's sign. 0x80000000 / -1 wraps to 0x80000000 rem 0.
    // Returns {remainder, quotient}; divisor must be non-zero.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        ma = a[31] ? (32'd0 - a) : a;
        mb = b[31] ? (32'd0 - b) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) begin
            q = 32'd0 - q;
        end
        if (a[31]) begin
            r = 32'd0 - r;
        end
        return {r, q};
    endfunction

    // Unsigned divide; returns {remainder, quotient}; divisor must be non-zero.
    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        return {a % b, a / b};
    endfunction

    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_lo_r;
    logic             pend_skip_r;
    logic [CNT_W-1:0] count_r;
    logic             busy_r;

    logic             op_valid_s;
    logic             is_div_s;
    logic             div_zero_s;
    logic [31:0]      safe_div_s;
    logic [63:0]      result_s;
    logic [CNT_W-1:0] load_s;

    // Decode hilo_op and form the 64-bit result from the current operands.
    always_comb begin
        op_valid_s = 1'b0;
        is_div_s   = 1'b0;
        result_s   = 64'd0;
        safe_div_s = (rt_data == 32'd0) ? 32'd1 : rt_data;
        case (hilo_op)
            4'd1: begin
                op_valid_s = 1'b1;
                result_s   = mul_signed(rs_data, rt_data);
            end
            4'd2: begin
                op_valid_s = 1'b1;
                result_s   = mul_unsigned(rs_data, rt_data);
            end
            4'd3: begin
                op_valid_s = 1'b1;
                is_div_s   = 1'b1;
                result_s   = div_signed(rs_data, safe_div_s);
            end
            4'd4: begin
                op_valid_s = 1'b1;
                is_div_s   = 1'b1;
                result_s   = div_unsigned(rs_data, safe_div_s);
            end
            default: begin
                op_valid_s = 1'b0;
                is_div_s   = 1'b0;
                result_s   = 64'd0;
            end
        endcase
        div_zero_s = is_div_s && (rt_data == 32'd0);
        load_s     = is_div_s ? DIV_LOAD : MULT_LOAD;
    end

    // Countdown sequencer: launch ops, commit pending results, handle MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            pend_hi_r   <= 32'd0;
            pend_lo_r   <= 32'd0;
            pend_skip_r <= 1'b0;
            count_r     <= CNT_ZERO;
            busy_r      <= 1'b0;
        end else if (count_r == CNT_ZERO) begin
            if (start) begin
                if (op_valid_s) begin
                    pend_hi_r   <= result_s[63:32];
                    pend_lo_r   <= result_s[31:0];
                    pend_skip_r <= div_zero_s;
                    count_r     <= load_s;
                    busy_r      <= 1'b1;
                end else begin
                    busy_r      <= 1'b0;
                end
            end else if (write_hl == 2'd1) begin
                hi_r <= rs_data;
            end else if (write_hl == 2'd2) begin
                lo_r <= rs_data;
            end else begin
                busy_r <= 1'b0;
            end
        end else begin
            count_r <= count_r - CNT_ONE;
            busy_r  <= (count_r != CNT_ONE);
            if ((count_r == CNT_ONE) && !pend_skip_r) begin
                hi_r <= pend_hi_r;
                lo_r <= pend_lo_r;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    // MFHI/MFLO read port feeding the E-stage result mux.
    always_comb begin
        case (read_hl)
            2'd1:    hilo_out = hi_r;
            2'd2:    hilo_out = lo_r;
            default: hilo_out = 32'd0;
        endcase
    end

    assign busy = busy_r;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed vector table, hand-written corner sequences and
// randomized ops checked against a 64-bit integer reference model.
module tb_mdu_hilo;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  hilo_op = 4'd0;
    logic [1:0]  write_hl = 2'd0;
    logic [1:0]  read_hl = 2'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        busy;
    logic [31:0] hilo_out;

    mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .hilo_op(hilo_op),
        .write_hl(write_hl), .read_hl(read_hl), .rs_data(rs_data),
        .rt_data(rt_data), .busy(busy), .hilo_out(hilo_out)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Reference: plain 64-bit integer arithmetic, returns {hi, lo}.
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        case (op)
            4'd1: res = sa * sb;
            4'd2: res = ua * ub;
            4'd3: begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            4'd4: begin q = longint'(ua / ub); r = longint'(ua % ub); res = {r[31:0], q[31:0]}; end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    function automatic int cycles_of(input logic [3:0] op);
        return (op >= 4'd3) ? DC : MC;
    endfunction

    task automatic check_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        read_hl = 2'd1; #1; chk({tag, "_hi"}, hilo_out, eh);
        read_hl = 2'd2; #1; chk({tag, "_lo"}, hilo_out, el);
        read_hl = 2'd0; #1;
    endtask

    // Count busy cycles from the current negedge until busy falls (bounded).
    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Launch one op, check busy length, leave the bench at the commit cycle.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int n;
        @(negedge clk);
        start = 1'b1; hilo_op = op; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0; hilo_op = 4'd0;
        wait_busy(n);
        chk({tag, "_busy_cycles"}, 32'(n), 32'(cycles_of(op)));
    endtask

    task automatic do_write(input logic [1:0] wh, input logic [31:0] v);
        @(negedge clk);
        write_hl = wh; rs_data = v;
        @(negedge clk);
        write_hl = 2'd0;
        if (wh == 2'd1) m_hi = v;
        else if (wh == 2'd2) m_lo = v;
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        logic [63:0] r;
        logic [3:0] op;
        logic [31:0] a, b;
        int kind;

        vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{4'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{4'd4, 32'd7,        32'd2, 32'd1,        32'd3};
        vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000};
        vecs[5] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
        vecs[6] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
        vecs[7] = '{4'd4, 32'hFFFFFFFF, 32'd16, 32'd15, 32'h0FFFFFFF};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        check_hilo("reset", 32'd0, 32'd0);
        reset_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt);
            check_hilo($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
            m_hi = vecs[i].hi; m_lo = vecs[i].lo;
        end

        // read_hl 0/3 read as zero
        read_hl = 2'd3; #1; chk("read3_zero", hilo_out, 32'd0); read_hl = 2'd0;

        // MTHI then MFHI, then divide by zero leaves HI/LO alone
        do_write(2'd1, 32'h12345678);
        check_hilo("mthi", 32'h12345678, m_lo);
        do_op("divzero", 4'd3, 32'd5, 32'd0);
        check_hilo("divzero", 32'h12345678, m_lo);

        // Invalid op start: no busy, no change
        @(negedge clk);
        start = 1'b1; hilo_op = 4'd5; rs_data = 32'd9; rt_data = 32'd9;
        @(negedge clk);
        start = 1'b0; hilo_op = 4'd0;
        chk("badop_busy", {31'd0, busy}, 32'd0);
        check_hilo("badop", m_hi, m_lo);

        // MULT start and MTHI during a DIV are ignored
        @(negedge clk);
        start = 1'b1; hilo_op = 4'd3; rs_data = 32'd100; rt_data = 32'd7;
        @(negedge clk);
        hilo_op = 4'd1; rs_data = 32'd3; rt_data = 32'd3;
        @(negedge clk);
        start = 1'b0; hilo_op = 4'd0; write_hl = 2'd1; rs_data = 32'hDEADBEEF;
        @(negedge clk);
        write_hl = 2'd0;
        wait_busy(n);
        chk("busy_ignore_cycles", 32'(n + 3), 32'(DC + 1));
        check_hilo("busy_ignore", 32'd2, 32'd14);
        m_hi = 32'd2; m_lo = 32'd14;
        @(negedge clk);
        chk("busy_ignore_idle", {31'd0, busy}, 32'd0);

        // Reset on cycle 3 of a MULT aborts it
        @(negedge clk);
        start = 1'b1; hilo_op = 4'd1; rs_data = 32'd6; rt_data = 32'd7;
        @(negedge clk);
        start = 1'b0; hilo_op = 4'd0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        check_hilo("abort", 32'd0, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        do_op("after_reset", 4'd1, 32'd6, 32'd7);
        check_hilo("after_reset", 32'd0, 32'd42);
        m_lo = 32'd42;

        // start with MTLO in the same cycle: start wins
        @(negedge clk);
        start = 1'b1; hilo_op = 4'd1; write_hl = 2'd2; rs_data = 32'd3; rt_data = 32'd4;
        @(negedge clk);
        start = 1'b0; hilo_op = 4'd0; write_hl = 2'd0;
        wait_busy(n);
        chk("start_mtlo_cycles", 32'(n), 32'(MC));
        check_hilo("start_mtlo", 32'd0, 32'd12);
        m_hi = 32'd0; m_lo = 32'd12;

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 5);
            a = $urandom();
            b = $urandom();
            if (kind >= 4) begin
                do_write((kind == 4) ? 2'd1 : 2'd2, a);
            end else begin
                op = 4'(kind + 1);
                if (op >= 4'd3 && $urandom_range(0, 7) == 0) b = 32'd0;
                do_op($sformatf("rnd%0d", i), op, a, b);
                if (!(op >= 4'd3 && b == 32'd0)) begin
                    r = ref_result(op, a, b);
                    m_hi = r[63:32]; m_lo = r[31:0];
                end
            end
            check_hilo($sformatf("rnd%0d", i), m_hi, m_lo);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
